// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-lite definitions for the on-chip RAM responder.
//   - response codes, AxPROT encodings, instruction-access prot bit index
//   - read-path FSM state type
//   - addr_err(): decode helper, flags out-of-window or misaligned addresses
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] PROT_INST = 3'b101;
  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam int unsigned PROT_INST_BIT = 2;

  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  // Error when below the window, beyond the last word, or not word aligned.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || ((off >> 2) >= depth) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ram_1r1w.sv
// ram_1r1w: DEPTH x 32-bit storage, one synchronous read port and one
// synchronous byte-masked write port. A read and write to the same word in
// the same cycle returns the old contents (read-before-write).
//   clk      in   clock
//   i_re     in   read enable, o_rdata updates on the next edge
//   i_raddr  in   read word index
//   o_rdata  out  registered read data (held while i_re low)
//   i_we     in   write enable
//   i_waddr  in   write word index
//   i_wdata  in   write data
//   i_wstrb  in   per-byte write enables
module ram_1r1w #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Storage is not reset; both ports sample on the same edge so the read
  // sees the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_ram.sv
// axi_lite_ram: AXI4-lite responder in front of a word-organised RAM.
// One outstanding read and one outstanding write; independent channels.
// Optional feature macro: AXI_RAM_PROT_CHECK_EN -- when defined, writes with
// awprot[2] set (instruction access) get SLVERR and leave the RAM untouched.
// Ports:
//   clk, reset (async, active low)
//   aw*: awvalid/awready/awaddress/awprot   write address
//   w* : wvalid/wready/wdata/wrstrb         write data, byte strobes
//   b* : bvalid/bready/bresp                write response
//   ar*: arvalid/arready/araddress/arprot   read address
//   r* : rvalid/rready/rdata/rresp          read data
module axi_lite_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddress,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wrstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddress,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);
  import axi_lite_pkg::*;

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  // Readies stay low until the first edge after reset release.
  logic r_live;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // ---------------- read path ----------------
  rstate_e     r_rstate, w_rnext;
  logic        r_rerr;
  logic        w_ar_hs, w_rd_err;
  logic [31:0] w_rd_off, w_ram_rdata;

  assign w_ar_hs  = arvalid && arready;
  assign w_rd_err = addr_err(araddress, BASE_ADDR, DEPTH32);
  assign w_rd_off = araddress - BASE_ADDR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstate <= R_IDLE;
      r_rerr   <= 1'b0;
    end else begin
      r_rstate <= w_rnext;
      if (w_ar_hs) r_rerr <= w_rd_err;
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs)          w_rnext = R_RESP;
      R_RESP: if (rvalid && rready) w_rnext = R_IDLE;
      default:                      w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE:  arready = r_live;
      R_RESP:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  // RAM output register only changes on an AR handshake, so rdata is stable
  // while the response waits; error reads are forced to zero.
  always_comb begin
    rdata = 32'h0;
    rresp = RESP_OKAY;
    if (rvalid) begin
      if (r_rerr) rresp = RESP_SLVERR;
      else        rdata = w_ram_rdata;
    end
  end

  // ---------------- write path ----------------
  logic        r_aw_held, r_w_held, r_bvalid;
  logic [1:0]  r_bresp;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        w_aw_hs, w_w_hs, w_commit, w_wr_err, w_prot_err;
  logic [31:0] w_eff_addr, w_eff_data, w_wr_off;
  logic [3:0]  w_eff_strb;

  assign awready = r_live && !r_aw_held && !r_bvalid;
  assign wready  = r_live && !r_w_held  && !r_bvalid;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid  && wready;

  // Use the held copy if the channel already handshook, else the live bus.
  assign w_eff_addr = r_aw_held ? r_awaddr : awaddress;
  assign w_eff_data = r_w_held  ? r_wdata  : wdata;
  assign w_eff_strb = r_w_held  ? r_wstrb  : wrstrb;
  assign w_wr_off   = w_eff_addr - BASE_ADDR;

  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_err = addr_err(w_eff_addr, BASE_ADDR, DEPTH32) || w_prot_err;

`ifdef AXI_RAM_PROT_CHECK_EN
  logic [2:0] r_awprot, w_eff_prot;
  logic       w_unused_prot;
  assign w_eff_prot    = r_aw_held ? r_awprot : awprot;
  assign w_prot_err    = w_eff_prot[PROT_INST_BIT];
  assign w_unused_prot = ^{arprot, w_eff_prot};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_awprot <= PROT_DATA;
    else if (w_aw_hs) r_awprot <= awprot;
  end
`else
  logic w_unused_prot;
  assign w_prot_err    = 1'b0;
  assign w_unused_prot = ^{arprot, awprot};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= 32'h0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
    end else begin
      if (r_bvalid && bready) r_bvalid <= 1'b0;
      if (w_aw_hs) r_awaddr <= awaddress;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wrstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
      end
    end
  end

  // Only the word-index bits of the offsets reach the RAM.
  logic w_unused_off;
  assign w_unused_off = ^{w_rd_off, w_wr_off, w_unused_prot};

  ram_1r1w #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .i_re    (w_ar_hs && !w_rd_err),
    .i_raddr (w_rd_off[AW+1:2]),
    .o_rdata (w_ram_rdata),
    .i_we    (w_commit && !w_wr_err),
    .i_waddr (w_wr_off[AW+1:2]),
    .i_wdata (w_eff_data),
    .i_wstrb (w_eff_strb)
  );

endmodule

// File: tb/tb_axi_lite_ram.sv
module tb_axi_lite_ram;
  logic        clk = 1'b0, reset = 1'b0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddress = '0, wdata = '0, araddress = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wrstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_vec = 0, n_err = 0;

  axi_lite_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wrstrb(wrstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus helper: AW and W presented together; returns bresp and whether
  // bvalid was up right after the final handshake edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p,
                           output logic [1:0] resp, output logic lat);
    logic aw_done, w_done, aw_hs, w_hs;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    awaddress = a; awprot = p; wdata = d; wrstrb = s;
    awvalid = 1; wvalid = 1;
    while (!(aw_done && w_done) && t < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs)  begin wvalid = 0;  w_done = 1;  end
      t++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      n_vec++; n_err++;
      $display("FAIL wr_handshake_timeout addr=%h", a);
    end
    lat = bvalid;
    t = 0;
    while (!bvalid && t < 20) begin @(posedge clk); #1; t++; end
    resp = bresp;
    bready = 1; @(posedge clk); #1; bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [2:0] p,
                          output logic [31:0] d, output logic [1:0] resp,
                          output logic lat);
    logic hs;
    int t;
    hs = 0; t = 0;
    araddress = a; arprot = p; arvalid = 1;
    while (!hs && t < 20) begin
      hs = arready;
      @(posedge clk); #1;
      t++;
    end
    arvalid = 0;
    if (!hs) begin
      n_vec++; n_err++;
      $display("FAIL rd_handshake_timeout addr=%h", a);
    end
    lat = rvalid;
    t = 0;
    while (!rvalid && t < 20) begin @(posedge clk); #1; t++; end
    d = rdata; resp = rresp;
    rready = 1; @(posedge clk); #1; rready = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=00000", {awready, wready, bvalid, arready, rvalid});
    end
    n_vec++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      n_err++; $display("FAIL reset_data got=%h exp=0", {bresp, rresp, rdata});
    end
    @(negedge clk); reset = 1; #1;
    n_vec++;
    if (arready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge got=%b exp=0", arready); end
    @(posedge clk); #1;
    n_vec++;
    if ({arready, awready, wready} !== 3'b111) begin
      n_err++; $display("FAIL ready_after_edge got=%b exp=111", {arready, awready, wready});
    end
  endtask

  task automatic test_basic;
    logic [1:0] r; logic l; logic [31:0] d;
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, r, l);
    n_vec++;
    if ({l, r} !== 3'b100) begin n_err++; $display("FAIL basic_bresp got lat=%b resp=%b exp lat=1 resp=00", l, r); end
    axi_read(32'h10, 3'b000, d, r, l);
    n_vec++;
    if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL basic_rdata got=%h exp=deadbeef", d); end
    n_vec++;
    if ({l, r} !== 3'b100) begin n_err++; $display("FAIL basic_rresp got lat=%b resp=%b exp lat=1 resp=00", l, r); end
  endtask

  task automatic test_strobe;
    logic [1:0] r; logic l; logic [31:0] d;
    axi_write(32'h20, 32'h0, 4'hF, 3'b000, r, l);
    axi_write(32'h20, 32'h1122_3344, 4'b0101, 3'b000, r, l);
    axi_read(32'h20, 3'b000, d, r, l);
    n_vec++;
    if (d !== 32'h0022_0044) begin n_err++; $display("FAIL strobe_0101 got=%h exp=00220044", d); end
    axi_write(32'h20, 32'hFFFF_FFFF, 4'b0000, 3'b000, r, l);
    n_vec++;
    if (r !== 2'b00) begin n_err++; $display("FAIL strobe_zero_bresp got=%b exp=00", r); end
    axi_read(32'h20, 3'b000, d, r, l);
    n_vec++;
    if (d !== 32'h0022_0044) begin n_err++; $display("FAIL strobe_zero_data got=%h exp=00220044", d); end
  endtask

  task automatic test_errors;
    logic [1:0] r; logic l; logic [31:0] d;
    axi_read(32'h1000, 3'b000, d, r, l);
    n_vec++;
    if ({r, d} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL rd_oob got resp=%b data=%h exp resp=10 data=0", r, d); end
    axi_read(32'h11, 3'b000, d, r, l);
    n_vec++;
    if ({r, d} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL rd_misaligned got resp=%b data=%h exp resp=10 data=0", r, d); end
    axi_write(32'h0, 32'h55AA_55AA, 4'hF, 3'b000, r, l);
    axi_write(32'h2, 32'hFFFF_FFFF, 4'hF, 3'b000, r, l);
    n_vec++;
    if (r !== 2'b10) begin n_err++; $display("FAIL wr_misaligned got=%b exp=10", r); end
    axi_read(32'h0, 3'b000, d, r, l);
    n_vec++;
    if (d !== 32'h55AA_55AA) begin n_err++; $display("FAIL wr_misaligned_untouched got=%h exp=55aa55aa", d); end
    axi_write(32'hFFFF_FFFC, 32'h1, 4'hF, 3'b000, r, l);
    n_vec++;
    if (r !== 2'b10) begin n_err++; $display("FAIL wr_oob got=%b exp=10", r); end
    axi_write(32'hFFC, 32'h7777_8888, 4'hF, 3'b000, r, l);
    axi_read(32'hFFC, 3'b000, d, r, l);
    n_vec++;
    if ({r, d} !== {2'b00, 32'h7777_8888}) begin n_err++; $display("FAIL last_word got resp=%b data=%h exp resp=00 data=77778888", r, d); end
  endtask

  task automatic test_w_first_stall;
    logic [1:0] r; logic l; logic [31:0] d;
    wdata = 32'hCAFE_F00D; wrstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1; wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        n_err++; $display("FAIL w_held_%0d got wr/aw/b=%b exp=010", i, {wready, awready, bvalid});
      end
      if (i == 2) begin awaddress = 32'h30; awprot = 3'b000; awvalid = 1; end
      @(posedge clk); #1;
    end
    awvalid = 0;
    n_vec++;
    if (bvalid !== 1'b1) begin n_err++; $display("FAIL w_first_latency got bvalid=%b exp=1", bvalid); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bvalid, awready, wready, bresp} !== 5'b10000) begin
        n_err++; $display("FAIL b_stall_%0d got b/aw/w/resp=%b exp=10000", i, {bvalid, awready, wready, bresp});
      end
      @(posedge clk); #1;
    end
    bready = 1; @(posedge clk); #1; bready = 0;
    n_vec++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_err++; $display("FAIL b_release got b/aw/w=%b exp=011", {bvalid, awready, wready});
    end
    axi_read(32'h30, 3'b000, d, r, l);
    n_vec++;
    if (d !== 32'hCAFE_F00D) begin n_err++; $display("FAIL w_first_data got=%h exp=cafef00d", d); end
  endtask

  task automatic test_collision;
    logic [1:0] r; logic l; logic [31:0] d;
    axi_write(32'h40, 32'h0, 4'hF, 3'b000, r, l);
    awaddress = 32'h40; awprot = 0; wdata = 32'hA5A5_A5A5; wrstrb = 4'hF;
    araddress = 32'h40; arprot = 0;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    n_vec++;
    if ({rvalid, bvalid, rdata} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL collision_old got rv/bv=%b data=%h exp rv/bv=11 data=0", {rvalid, bvalid}, rdata);
    end
    rready = 1; bready = 1; @(posedge clk); #1; rready = 0; bready = 0;
    axi_read(32'h40, 3'b000, d, r, l);
    n_vec++;
    if (d !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL collision_new got=%h exp=a5a5a5a5", d); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] r; logic l;
    axi_write(32'h14, 32'h0BAD_F00D, 4'hF, 3'b000, r, l);
    araddress = 32'h10; arprot = 0; arvalid = 1; rready = 1;
    @(posedge clk); #1;
    arvalid = 0;
    n_vec++;
    if ({rvalid, arready, rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL b2b_first got rv/ar=%b data=%h exp rv/ar=10 data=deadbeef", {rvalid, arready}, rdata);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({rvalid, arready} !== 2'b01) begin n_err++; $display("FAIL b2b_ready_back got rv/ar=%b exp=01", {rvalid, arready}); end
    araddress = 32'h14; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    n_vec++;
    if ({rvalid, rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      n_err++; $display("FAIL b2b_second got rv=%b data=%h exp rv=1 data=0badf00d", rvalid, rdata);
    end
    @(posedge clk); #1; rready = 0;
  endtask

  task automatic test_prot;
    logic [1:0] r; logic l; logic [31:0] d;
    axi_write(32'h60, 32'h0, 4'hF, 3'b000, r, l);
    axi_write(32'h60, 32'h7777_7777, 4'hF, 3'b101, r, l);
    axi_read(32'h60, 3'b101, d, r, l);
`ifdef AXI_RAM_PROT_CHECK_EN
    n_vec++;
    if (d !== 32'h0) begin n_err++; $display("FAIL prot_inst_write got=%h exp=0", d); end
`else
    n_vec++;
    if (d !== 32'h7777_7777) begin n_err++; $display("FAIL prot_ignored_write got=%h exp=77777777", d); end
`endif
    n_vec++;
    if (r !== 2'b00) begin n_err++; $display("FAIL prot_read_resp got=%b exp=00", r); end
    axi_write(32'h60, 32'h1, 4'hF, 3'b101, r, l);
`ifdef AXI_RAM_PROT_CHECK_EN
    n_vec++;
    if (r !== 2'b10) begin n_err++; $display("FAIL prot_bresp got=%b exp=10", r); end
`else
    n_vec++;
    if (r !== 2'b00) begin n_err++; $display("FAIL prot_bresp got=%b exp=00", r); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [1:0] r; logic l; logic [31:0] d;
    axi_write(32'h50, 32'h1234_5678, 4'hF, 3'b000, r, l);
    wdata = 32'hFFFF_FFFF; wrstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1; wvalid = 0;
    araddress = 32'h50; arprot = 0; arvalid = 1;
    @(posedge clk); #1; arvalid = 0;
    n_vec++;
    if ({rvalid, rdata} !== {1'b1, 32'h1234_5678}) begin
      n_err++; $display("FAIL mid_pre got rv=%b data=%h exp rv=1 data=12345678", rvalid, rdata);
    end
    #2 reset = 0; #1;
    n_vec++;
    if ({rvalid, bvalid, arready, awready, wready, rdata} !== 37'h0) begin
      n_err++; $display("FAIL mid_async got rv/bv/ar/aw/w=%b data=%h exp all 0",
                        {rvalid, bvalid, arready, awready, wready}, rdata);
    end
    @(negedge clk); reset = 1; #1;
    n_vec++;
    if (arready !== 1'b0) begin n_err++; $display("FAIL mid_ready_early got=%b exp=0", arready); end
    @(posedge clk); #1;
    n_vec++;
    if (arready !== 1'b1) begin n_err++; $display("FAIL mid_ready_edge got=%b exp=1", arready); end
    axi_read(32'h50, 3'b000, d, r, l);
    n_vec++;
    if (d !== 32'h1234_5678) begin n_err++; $display("FAIL mid_no_partial got=%h exp=12345678", d); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_strobe;
    test_errors;
    test_w_first_stall;
    test_collision;
    test_back_to_back;
    test_prot;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
